// File: rtl/booth_r4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier. Each RUN cycle it recodes one
// multiplier digit and uses an external N+2-bit adder to accumulate it.
module booth_r4_seq_mult #(
  parameter int N     = 16,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   product,
  output logic             busy,
  output logic [N+1:0]     add_x,
  output logic [N+1:0]     add_y,
  output logic             add_ci,
  input  logic [N+1:0]     add_s,
  input  logic             add_co
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [N-1:0]       areg_r;
  logic [N+1:0]       acc_r;
  logic [N-1:0]       mq_r;
  logic               qm1_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*N-1:0]     product_r;
  logic               out_valid_r;
  logic               busy_r;

  logic [N+1:0]       sext_a_s;
  logic [N+2:0]       pp_s;
  logic [N+1:0]       acc_nxt_s;
  logic [N-1:0]       mq_nxt_s;
  logic               last_step_s;
  logic               unused_add_co_s;

  // Booth digit recode: returns {ci, y}; negative digits are ones' complement plus ci.
  function automatic logic [N+2:0] booth_pp(input logic [2:0] t, input logic [N+1:0] ax);
    logic [N+2:0] r;
    case (t)
      3'b000, 3'b111: r = {1'b0, {(N+2){1'b0}}};
      3'b001, 3'b010: r = {1'b0, ax};
      3'b011:         r = {1'b0, ax[N:0], 1'b0};
      3'b100:         r = {1'b1, ~{ax[N:0], 1'b0}};
      3'b101, 3'b110: r = {1'b1, ~ax};
      default:        r = {1'b0, {(N+2){1'b0}}};
    endcase
    return r;
  endfunction

  assign sext_a_s        = {{2{areg_r[N-1]}}, areg_r};
  assign pp_s            = booth_pp({mq_r[1:0], qm1_r}, sext_a_s);
  assign acc_nxt_s       = {add_s[N+1], add_s[N+1], add_s[N+1:2]};
  assign mq_nxt_s        = {add_s[1:0], mq_r[N-1:2]};
  assign last_step_s     = (cnt_r == CNT_W'(N/2-1));
  assign unused_add_co_s = add_co;

  // Adder operands are only presented while stepping; quiet otherwise.
  always_comb begin
    add_x  = {(N+2){1'b0}};
    add_y  = {(N+2){1'b0}};
    add_ci = 1'b0;
    if (state_r == RUN) begin
      add_x  = acc_r;
      add_y  = pp_s[N+1:0];
      add_ci = pp_s[N+2];
    end else begin
      add_x  = {(N+2){1'b0}};
      add_y  = {(N+2){1'b0}};
      add_ci = 1'b0;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      areg_r      <= {N{1'b0}};
      acc_r       <= {(N+2){1'b0}};
      mq_r        <= {N{1'b0}};
      qm1_r       <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      product_r   <= {(2*N){1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            areg_r  <= a;
            mq_r    <= b;
            qm1_r   <= 1'b0;
            acc_r   <= {(N+2){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          acc_r <= acc_nxt_s;
          mq_r  <= mq_nxt_s;
          qm1_r <= mq_r[1];
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (last_step_s) begin
            // Upper two accumulator bits are pure sign extension here.
            product_r   <= {acc_nxt_s[N-1:0], mq_nxt_s};
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign product   = product_r;
  assign busy      = busy_r;

endmodule
